// File: rtl/div_clk_monitor.sv
// Period/lock checker for a divided clock sampled in the fast clk domain.
// Optional duty-cycle checking and the duty_err port are enabled by DIV_CLK_MON_DUTY_EN.
module div_clk_monitor #(
    parameter int HALF_PERIOD = 32768,
    parameter int TOL         = 2,
    parameter int LOCK_CNT    = 4,
    parameter int CNT_W       = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_in,
    input  logic             fault_clr,
`ifdef DIV_CLK_MON_DUTY_EN
    output logic             duty_err,
`endif
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             fault
);
    typedef enum logic [1:0] {IDLE, ACQ, LOCKED, FLT} state_t;

    localparam logic [CNT_W:0] NOM    = (CNT_W+1)'(2*HALF_PERIOD);
    localparam logic [CNT_W:0] HALF_W = (CNT_W+1)'(HALF_PERIOD);
    localparam logic [CNT_W:0] TOL_W  = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0] THRESH = (CNT_W+1)'(2*HALF_PERIOD+TOL+1);
    localparam logic [3:0]     LOCK_LAST = 4'(LOCK_CNT-1);

    // Comparisons run one bit wider than the counter so nothing wraps.
    function automatic logic in_tol(input logic [CNT_W:0] v, input logic [CNT_W:0] nom);
        logic [CNT_W:0] d;
        d = (v >= nom) ? v - nom : nom - v;
        return d <= TOL_W;
    endfunction

    logic             s1_q, s2_q, prev_q;
    logic             rise, clr, ref_edge, meas, tmo, per_ok, duty_ok, good;
    logic [CNT_W:0]   per_meas;
    state_t           state_q, state_d;
    logic [3:0]       gcnt_q, gcnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, period_q, period_d;
    logic             vld_q, vld_d, locked_q, fault_q;

    assign rise     = s2_q & ~prev_q;
    assign per_meas = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign clr      = (state_q == FLT) && fault_clr;
    // An edge coinciding with a fault clear only restarts the measurement.
    assign ref_edge = (state_q == IDLE) || clr;
    assign meas     = rise && !ref_edge;
    assign per_ok   = in_tol(per_meas, NOM);
    assign tmo      = !rise && (state_q == ACQ || state_q == LOCKED) && (per_meas == THRESH);
    assign good     = per_ok && duty_ok;

`ifdef DIV_CLK_MON_DUTY_EN
    logic             fall, duty_err_q;
    logic [CNT_W-1:0] hi_q;
    logic [CNT_W:0]   lo_meas;

    assign fall    = ~s2_q & prev_q;
    assign lo_meas = per_meas - {1'b0, hi_q};
    assign duty_ok = in_tol({1'b0, hi_q}, HALF_W) && in_tol(lo_meas, HALF_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q       <= '0;
            duty_err_q <= 1'b0;
        end else begin
            if (fall) hi_q <= per_meas[CNT_W] ? '1 : per_meas[CNT_W-1:0];
            duty_err_q <= meas && !duty_ok;
        end
    end
    assign duty_err = duty_err_q;
`else
    assign duty_ok = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        gcnt_d   = gcnt_q;
        period_d = period_q;
        vld_d    = 1'b0;
        cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        if (rise || clr) cnt_d = '0;
        if (meas) begin
            period_d = per_meas[CNT_W] ? '1 : per_meas[CNT_W-1:0];
            vld_d    = 1'b1;
        end
        case (state_q)
            IDLE: if (rise) begin
                state_d = ACQ;
                gcnt_d  = '0;
            end
            ACQ: begin
                if (meas && good) begin
                    if (gcnt_q == LOCK_LAST) state_d = LOCKED;
                    gcnt_d = gcnt_q + 4'd1;
                end else if ((meas && !good) || tmo) begin
                    gcnt_d = '0;
                end
            end
            LOCKED: if ((meas && !good) || tmo) state_d = FLT;
            FLT: if (fault_clr) begin
                state_d = rise ? ACQ : IDLE;
                gcnt_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            prev_q   <= 1'b0;
            state_q  <= IDLE;
            gcnt_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            vld_q    <= 1'b0;
            locked_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            s1_q     <= div_in;
            s2_q     <= s1_q;
            prev_q   <= s2_q;
            state_q  <= state_d;
            gcnt_q   <= gcnt_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            // Status registered from next state so it lines up with period_vld.
            locked_q <= (state_d == LOCKED);
            fault_q  <= (state_d == FLT);
        end
    end

    assign period     = period_q;
    assign period_vld = vld_q;
    assign locked     = locked_q;
    assign fault      = fault_q;
endmodule

// File: tb/tb_div_clk_monitor.sv
// Scoreboard bench for div_clk_monitor with HALF_PERIOD=8, TOL=1, LOCK_CNT=4, CNT_W=8.
module tb_div_clk_monitor;
    logic       clk = 1'b0, rst_n = 1'b0, div_in = 1'b0, fault_clr = 1'b0;
    logic [7:0] period;
    logic       period_vld, locked, fault;
`ifdef DIV_CLK_MON_DUTY_EN
    logic       duty_err;
`endif

    div_clk_monitor #(.HALF_PERIOD(8), .TOL(1), .LOCK_CNT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .div_in(div_in), .fault_clr(fault_clr),
`ifdef DIV_CLK_MON_DUTY_EN
        .duty_err(duty_err),
`endif
        .period(period), .period_vld(period_vld), .locked(locked), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct { int per; bit lk; bit ft; bit du; } exp_t;
    exp_t exp_q[$];
    int   checks = 0, errs = 0, cyc = 0, last_vld = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Expected entry derived from the stimulus phases of one period.
    task automatic push(input int hi, input int lo, input bit lk, input bit ft);
        exp_t e;
        e.per = hi + lo;
        e.lk  = lk;
        e.ft  = ft;
        e.du  = (hi > 9 || hi < 7 || lo > 9 || lo < 7);
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && period_vld) begin
            last_vld = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_period_vld", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("period", int'(period), e.per);
                chk("locked", int'(locked), int'(e.lk));
                chk("fault", int'(fault), int'(e.ft));
`ifdef DIV_CLK_MON_DUTY_EN
                chk("duty_err", int'(duty_err), int'(e.du));
`endif
            end
        end
    end

    task automatic cw(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic per(input int hi, input int lo);
        div_in = 1'b1; cw(hi);
        div_in = 1'b0; cw(lo);
    endtask

    task automatic pulse_clr();
        fault_clr = 1'b1; cw(1);
        fault_clr = 1'b0; cw(1);
    endtask

    initial begin
        int fault_cyc;
        cw(3);
        chk("rst_period", int'(period), 0);
        chk("rst_vld", int'(period_vld), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_fault", int'(fault), 0);
        rst_n = 1'b1;
        cw(5);

        // Reference edge, lock, tolerance band, then one period over tolerance.
        for (int i = 0; i < 4; i++) push(8, 8, i == 3, 1'b0);
        push(8, 7, 1'b1, 1'b0);
        push(8, 9, 1'b1, 1'b0);
        push(8, 10, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) per(8, 8);
        per(8, 7); per(8, 9); per(8, 10); per(8, 8);
        cw(10);
        chk("fault_sticky", int'(fault), 1);

        // Clear, relock, then stall the input low.
        pulse_clr();
        chk("clr_fault", int'(fault), 0);
        for (int i = 0; i < 5; i++) push(8, 8, i >= 3, 1'b0);
        for (int i = 0; i < 5; i++) per(8, 8);
        div_in = 1'b1; cw(8);
        div_in = 1'b0;
        fault_cyc = -1;
        for (int i = 0; i < 60 && fault_cyc < 0; i++) begin
            @(negedge clk);
            if (fault) fault_cyc = cyc;
        end
        chk("timeout_seen", int'(fault_cyc >= 0), 1);
        if (fault_cyc >= 0) chk("timeout_delay", fault_cyc - last_vld, 18);
        chk("timeout_locked", int'(locked), 0);
        cw(2);

        // Bad period during acquisition restarts the good count; then async reset.
        pulse_clr();
        for (int i = 0; i < 3; i++) push(8, 8, 1'b0, 1'b0);
        push(6, 6, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(8, 8, i == 3, 1'b0);
        for (int i = 0; i < 3; i++) per(8, 8);
        per(6, 6);
        for (int i = 0; i < 4; i++) per(8, 8);
        div_in = 1'b1; cw(8);
        chk("pre_rst_locked", int'(locked), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_period", int'(period), 0);
        chk("async_locked", int'(locked), 0);
        chk("async_fault", int'(fault), 0);
        div_in = 1'b0;
        cw(3);
        rst_n = 1'b1;
        cw(5);

        // 10-high/6-low wave: period is nominal, duty is not.
        for (int i = 0; i < 5; i++) begin
`ifdef DIV_CLK_MON_DUTY_EN
            push(10, 6, 1'b0, 1'b0);
`else
            push(10, 6, i >= 3, 1'b0);
`endif
        end
        for (int i = 0; i < 6; i++) per(10, 6);
        cw(30);
`ifdef DIV_CLK_MON_DUTY_EN
        chk("duty_no_lock", int'(locked), 0);
        chk("duty_no_fault", int'(fault), 0);
`else
        chk("stall_fault", int'(fault), 1);
`endif
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
